stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Control FSM for the stopwatch seconds counter.
//   Takes start/stop, lap and clear buttons and synchronises and edge-detects them.
//   Divides clk down to a 1 Hz tick enable and sequences the counter through
//   idle, run, pause and lap-hold.
//   Drives the tick and count_clr inputs of the seconds counter and muxes the
//   live or lap value onto the display bus.
// PARAMETERS
//   CLK_HZ       100_000_000  clk frequency; prescaler period in cycles (>=2)
//   SEC_W        13           seconds counter width
//   SYNC_STAGES  2            button synchroniser depth (>=2)
// PORTS
//   clk             in   1      system clock, 100 MHz nominal
//   rst_n           in   1      asynchronous, active-low reset
//   btn_start_stop  in   1      async button, pre-debounced, active-high
//   btn_lap         in   1      async button, pre-debounced, active-high
//   btn_clear       in   1      async button, pre-debounced, active-high
//   seconds_live    in   SEC_W  current value from the seconds counter
//   tick            out  1      one-cycle count enable to the counter
//   count_clr       out  1      one-cycle synchronous clear to the counter
//   seconds_disp    out  SEC_W  registered display value (live or lap)
//   running         out  1      high in RUN and LAP
//   lap_active      out  1      high in LAP
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, prescaler=0, lap_reg=0.
//     - All outputs are 0 immediately, including mid-operation.
//   Buttons:
//     - Each button passes through SYNC_STAGES flops, then a rising-edge detector.
//     - The result is a 1-cycle pulse, SYNC_STAGES+1 cycles after the input rises.
//     - Holding a button produces exactly one pulse.
//   Priority when pulses coincide: start_stop > lap > clear. Lower-priority
//     pulses in the same cycle are dropped.
//   FSM (transition takes effect on the clock edge after the pulse):
//     IDLE  : ss -> RUN; clr -> count_clr pulse, stay IDLE; lap ignored.
//     RUN   : ss -> PAUSE; lap -> LAP and lap_reg<=seconds_live; clr ignored.
//     LAP   : lap -> RUN; ss -> PAUSE (lap released); clr ignored.
//     PAUSE : ss -> RUN; clr -> IDLE with count_clr pulse and prescaler<=0;
//             lap ignored.
//   Prescaler:
//     - Counts 0..CLK_HZ-1 only in RUN/LAP and wraps to 0.
//     - tick=1 for the cycle in which prescaler==CLK_HZ-1.
//     - Holds its value in PAUSE, so a resume completes the interrupted second.
//     - Is 0 in IDLE.
//   Saturation: tick is suppressed while seconds_live=={SEC_W{1}}. The
//     prescaler keeps wrapping and the state is unchanged.
//   Display:
//     - seconds_disp <= (state==LAP) ? lap_reg : seconds_live, one cycle of latency.
//     - Leaving LAP makes it follow live on the next cycle.
//   count_clr: exactly one cycle per accepted clear; never coincides with tick.
//   running/lap_active: decoded from the registered state, glitch-free.
// STRUCTURE
//   stopwatch_pkg:
//     - state encoding localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP.
//     - default CLK_HZ and SEC_W constants.
//   Sub-module btn_edge (SYNC_STAGES synchroniser + rising-edge pulse):
//     - instantiated three times.
//   Remainder is in stopwatch_ctrl:
//     - FSM, prescaler of width $clog2(CLK_HZ), lap_reg, display register.
// TESTING (bench uses CLK_HZ=10; a model counter increments on tick)
//   1. Reset, pulse start_stop, run 25 cycles after RUN entry
//      -> tick at cycles 10 and 20 only; seconds_live=2; running=1.
//   2. Stop with prescaler=6, wait 50 cycles -> no tick.
//      Restart -> first tick 4 cycles after RUN entry.
//   3. Lap at seconds_live=5 -> seconds_disp stays 5 while live reaches 7,
//      lap_active=1. Lap again -> seconds_disp=7 one cycle later.
//   4. Clear in RUN -> ignored. Stop, then clear -> count_clr high one cycle,
//      state IDLE, prescaler 0, running=0.
//   5. start_stop and lap pulse in the same cycle in RUN -> PAUSE, lap_reg unchanged.
//   6. seconds_live=8191 in RUN -> no tick for 30 cycles.
//      rst_n low mid-RUN -> all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control slice: FSM state encodings and
// default clock/counter sizing.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int SEC_W_DEF  = 13;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button front end: SYNC_STAGES-deep synchroniser followed by a registered
// rising-edge detector producing one single-cycle pulse per press.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Pulse is registered so it lands SYNC_STAGES+1 cycles after the input rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button front ends, IDLE/RUN/PAUSE/LAP sequencing, 1 Hz
// prescaler with saturation guard, lap capture and registered display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int SEC_W       = SEC_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  input  logic [SEC_W-1:0] seconds_live,
  output logic             tick,
  output logic             count_clr,
  output logic [SEC_W-1:0] seconds_disp,
  output logic             running,
  output logic             lap_active,
  output logic [1:0]       state_dbg
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_HZ - 1);

  logic             ss_p, lap_p, clr_p;
  logic             lap_acc, clr_acc;
  logic [1:0]       state, next_state;
  logic             lap_load, clr_fire, counting;
  logic [PW-1:0]    prescaler;
  logic [SEC_W-1:0] lap_reg;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss  (.clk(clk), .rst_n(rst_n), .btn(btn_start_stop), .pulse(ss_p));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (.clk(clk), .rst_n(rst_n), .btn(btn_lap),        .pulse(lap_p));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (.clk(clk), .rst_n(rst_n), .btn(btn_clear),      .pulse(clr_p));

  // Coincident pulses: start_stop wins over lap, lap wins over clear.
  assign lap_acc = lap_p & ~ss_p;
  assign clr_acc = clr_p & ~ss_p & ~lap_p;

  always_comb begin
    next_state = state;
    lap_load   = 1'b0;
    clr_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_p)         next_state = ST_RUN;
        else if (clr_acc) clr_fire   = 1'b1;
      end
      ST_RUN: begin
        if (ss_p) next_state = ST_PAUSE;
        else if (lap_acc) begin
          next_state = ST_LAP;
          lap_load   = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_p)         next_state = ST_PAUSE;
        else if (lap_acc) next_state = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_p) next_state = ST_RUN;
        else if (clr_acc) begin
          next_state = ST_IDLE;
          clr_fire   = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign counting = (state == ST_RUN) || (state == ST_LAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      prescaler    <= '0;
      lap_reg      <= '0;
      seconds_disp <= '0;
      count_clr    <= 1'b0;
    end else begin
      state     <= next_state;
      count_clr <= clr_fire;
      // Prescaler holds in PAUSE so a resume finishes the interrupted second.
      if (clr_fire)                           prescaler <= '0;
      else if (counting && prescaler == PS_MAX) prescaler <= '0;
      else if (counting)                      prescaler <= prescaler + PW'(1);
      if (lap_load) lap_reg <= seconds_live;
      seconds_disp <= (state == ST_LAP) ? lap_reg : seconds_live;
    end
  end

  // Tick is held off at full scale so the counter saturates instead of wrapping.
  assign tick       = counting && (prescaler == PS_MAX) && (seconds_live != '1);
  assign running    = counting;
  assign lap_active = (state == ST_LAP);
  assign state_dbg  = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=10: tick and count_clr events
// are scoreboarded by cycle stamp; state/display checked at fixed cycles.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int SEC_W = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_start_stop = 1'b0;
  logic             btn_lap = 1'b0;
  logic             btn_clear = 1'b0;
  logic [SEC_W-1:0] seconds_live = '0;
  logic             tick, count_clr, running, lap_active;
  logic [SEC_W-1:0] seconds_disp;
  logic [1:0]       state_dbg;

  logic             load_req = 1'b0;
  logic [SEC_W-1:0] load_val = '0;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [31:0]      tick_q[$];
  logic [31:0]      clr_q[$];
  int               e, e2, e3, e4;

  stopwatch_ctrl #(.CLK_HZ(10), .SEC_W(SEC_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .seconds_live(seconds_live), .tick(tick), .count_clr(count_clr),
    .seconds_disp(seconds_disp), .running(running), .lap_active(lap_active),
    .state_dbg(state_dbg)
  );

  // clock / reset-independent environment
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // seconds counter model driven by the DUT's tick/count_clr
  always @(posedge clk) begin
    if (load_req)       seconds_live <= load_val;
    else if (count_clr) seconds_live <= '0;
    else if (tick)      seconds_live <= seconds_live + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic wait_until(input int v);
    while (cyc < v) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask);
    btn_start_stop = mask[0];
    btn_lap        = mask[1];
    btn_clear      = mask[2];
    repeat (4) @(negedge clk);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  // monitor: pop expected cycle stamps whenever the DUT fires tick/count_clr
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick) begin
        if (tick_q.size() == 0) check("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
        else check("tick_cycle", 32'(cyc), tick_q.pop_front());
      end
      if (count_clr) begin
        if (clr_q.size() == 0) check("unexpected_count_clr", 32'(cyc), 32'hFFFF_FFFF);
        else check("count_clr_cycle", 32'(cyc), clr_q.pop_front());
        check("clr_with_tick", 32'(tick), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 0);
    check("rst_count_clr", 32'(count_clr), 0);
    check("rst_disp", 32'(seconds_disp), 0);
    check("rst_running", 32'(running), 0);
    check("rst_lap_active", 32'(lap_active), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: start, ticks every 10 cycles from RUN entry
    e = cyc + 4;
    tick_q.push_back(32'(e + 9));
    tick_q.push_back(32'(e + 19));
    tick_q.push_back(32'(e + 29));
    press(3'b001);
    wait_until(e + 24);
    check("t1_live", 32'(seconds_live), 2);
    check("t1_disp", 32'(seconds_disp), 2);
    check("t1_running", 32'(running), 1);
    check("t1_state", 32'(state_dbg), 32'(ST_RUN));

    // 2: stop with prescaler at 6, resume completes the second
    wait_until(e + 32);
    press(3'b001);
    wait_until(e + 37);
    check("t2_state_pause", 32'(state_dbg), 32'(ST_PAUSE));
    check("t2_running", 32'(running), 0);
    check("t2_live", 32'(seconds_live), 3);
    wait_until(e + 90);
    e2 = cyc + 4;
    for (int k = 0; k < 6; k++) tick_q.push_back(32'(e2 + 3 + 10 * k));
    press(3'b001);
    wait_until(e2 + 4);
    check("t2_resume_live", 32'(seconds_live), 4);

    // 3: lap freezes display at 5 while live advances
    wait_until(e2 + 15);
    press(3'b010);
    wait_until(e2 + 35);
    check("t3_live", 32'(seconds_live), 7);
    check("t3_disp_frozen", 32'(seconds_disp), 5);
    check("t3_lap_active", 32'(lap_active), 1);
    check("t3_running", 32'(running), 1);
    wait_until(e2 + 36);
    press(3'b010);
    check("t3_lap_released", 32'(lap_active), 0);
    check("t3_disp_lag", 32'(seconds_disp), 5);
    @(negedge clk);
    check("t3_disp_follow", 32'(seconds_disp), 7);

    // 4: clear ignored in RUN, honoured in PAUSE
    wait_until(e2 + 42);
    press(3'b100);
    wait_until(e2 + 50);
    check("t4_clr_ignored", 32'(state_dbg), 32'(ST_RUN));
    wait_until(e2 + 52);
    press(3'b001);
    wait_until(e2 + 57);
    check("t4_pause_live", 32'(seconds_live), 9);
    wait_until(e2 + 60);
    clr_q.push_back(32'(e2 + 64));
    press(3'b100);
    wait_until(e2 + 66);
    check("t4_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("t4_running", 32'(running), 0);
    check("t4_live", 32'(seconds_live), 0);
    check("t4_disp", 32'(seconds_disp), 0);
    check("t4_clr_q_drained", 32'(clr_q.size()), 0);
    wait_until(e2 + 70);
    e3 = cyc + 4;
    tick_q.push_back(32'(e3 + 9));  // prescaler restarted from 0
    press(3'b001);

    // 5: start_stop and lap together in RUN -> PAUSE
    wait_until(e3 + 12);
    press(3'b011);
    wait_until(e3 + 18);
    check("t5_state", 32'(state_dbg), 32'(ST_PAUSE));
    check("t5_lap_active", 32'(lap_active), 0);
    check("t5_disp", 32'(seconds_disp), 1);

    // 6: saturated counter gets no ticks; async reset clears outputs
    wait_until(e3 + 19);
    load_val = '1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    e4 = cyc + 4;
    press(3'b001);
    wait_until(e4 + 30);
    check("t6_live_sat", 32'(seconds_live), 8191);
    check("t6_disp_sat", 32'(seconds_disp), 8191);
    check("t6_running", 32'(running), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_disp", 32'(seconds_disp), 0);
    check("t6_async_running", 32'(running), 0);
    check("t6_async_state", 32'(state_dbg), 32'(ST_IDLE));
    check("t6_async_tick", 32'(tick), 0);
    check("t6_async_count_clr", 32'(count_clr), 0);
    check("tick_q_drained", 32'(tick_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
